mod3_scheduler: RTL and testbench

Shared bit-serial divisible-by-3 checker with a two-port round-robin front end. Two requesters submit WIDTH-bit words over valid/ready. The block grants one word at a time, runs it MSB-first through a 3-state remainder FSM, and returns the remainder, a divisible flag and the requester id over a valid/ready result port. It sits between the producer logic and any consumer that needs mod-3 classification, replacing per-requester combinational checkers with one sequenced engine.

---
 rtl/mod3_scheduler_pkg.sv | 25 ++
 rtl/mod3_scheduler_if.sv | 27 ++
 rtl/mod3_scheduler_serial_core.sv | 42 ++++
 rtl/mod3_scheduler.sv | 83 ++++++++
 tb/tb_mod3_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod3_scheduler_pkg.sv
// Shared types and the remainder step used by the mod-3 scheduler and its serial core.
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] REM0 = 2'd0;
  localparam logic [1:0] REM1 = 2'd1;
  localparam logic [1:0] REM2 = 2'd2;

  // (2*r + b) mod 3; the unreachable encoding 3 is folded onto remainder 0.
  function automatic logic [1:0] next_rem(input logic [1:0] r, input logic b);
    logic [1:0] n;
    case (r)
      REM1:    n = b ? REM0 : REM2;
      REM2:    n = b ? REM2 : REM1;
      default: n = b ? REM1 : REM0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mod3_scheduler_if.sv
// Request/result bundle between the two requesters, the consumer and the scheduler.
interface mod3_scheduler_if #(parameter int WIDTH = 8);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_rem;
  logic             res_div3;
  logic             res_id;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_rem, res_div3, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_rem, res_div3, res_id, busy
  );

endinterface

// File: rtl/mod3_scheduler_serial_core.sv
// Bit-serial remainder engine: shift register fed MSB-first into the mod-3 FSM.
module mod3_serial_core
  import mod3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_step,
  output logic [1:0]       o_rem,
  output logic             o_last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_rem   <= REM0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= CNT_W'(WIDTH);
      r_rem   <= REM0;
    end else if (i_step) begin
      r_rem   <= next_rem(r_rem, r_shift[WIDTH-1]);
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // Asserted during the final step, so the controller leaves SHIFT on that edge.
  assign o_last = (r_cnt == CNT_W'(1));
  assign o_rem  = r_rem;

endmodule

// File: rtl/mod3_scheduler.sv
// Two-port round-robin front end sharing one serial mod-3 engine; result held until consumed.
module mod3_scheduler
  import mod3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mod3_scheduler_if.slave bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_ptr;
  logic             r_id;
  logic [1:0]       w_valid;
  logic [1:0]       w_ready;
  logic             w_winner;
  logic             w_accept;
  logic [WIDTH-1:0] w_data;
  logic [1:0]       w_rem;
  logic             w_last;
  logic             w_done;

  assign w_valid  = {bus.req1_valid, bus.req0_valid};
  // r_ptr is the last-granted port; under contention the other one wins.
  assign w_winner = (w_valid == 2'b11) ? ~r_ptr : w_valid[1];
  assign w_data   = w_winner ? bus.req1_data : bus.req0_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign w_ready[gi] = rst_n & (r_state == IDLE) & w_valid[gi] & (w_winner == 1'(gi));
    end
  endgenerate

  assign w_accept       = |w_ready;
  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];

  mod3_serial_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_data (w_data),
    .i_step (r_state == SHIFT),
    .o_rem  (w_rem),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b1;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept)
        r_id <= w_winner;
      if (w_done && bus.res_ready)
        r_ptr <= r_id;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_next = SHIFT;
      SHIFT:   if (w_last)        w_state_next = DONE;
      DONE:    if (bus.res_ready) w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  // Result fields read as zero outside DONE so the idle/reset view is all-quiet.
  assign w_done        = (r_state == DONE);
  assign bus.res_valid = w_done;
  assign bus.res_rem   = w_done ? w_rem : REM0;
  assign bus.res_div3  = w_done & (w_rem == REM0);
  assign bus.res_id    = w_done & r_id;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mod3_scheduler.sv
// Scoreboard bench for mod3_scheduler: directed scenarios plus a shuffled all-values sweep.
module tb_mod3_scheduler;

  localparam int W = 8;

  typedef struct packed {
    logic       id;
    logic [1:0] rem;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  mod3_scheduler_if #(.WIDTH(W)) bus();

  mod3_scheduler #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input int p, input int v);
    exp_t e;
    e.id  = p[0];
    e.rem = 2'(v % 3);
    return e;
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.res_ready  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present a word on port p and return just after the accepting edge.
  task automatic drive(input int p, input logic [W-1:0] d);
    if (p == 0) begin bus.req0_data = d; bus.req0_valid = 1'b1; end
    else        begin bus.req1_data = d; bus.req1_valid = 1'b1; end
    forever begin
      @(negedge clk);
      if ((p == 0 && bus.req0_ready) || (p == 1 && bus.req1_ready)) break;
    end
    @(posedge clk);
    #1;
    if (p == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
    $display("request port=%0d data=0x%02h accepted", p, d);
  endtask

  task automatic get_result(output logic [1:0] rem, output logic dv, output logic id);
    forever begin
      @(negedge clk);
      if (bus.res_valid && bus.res_ready) break;
    end
    rem = bus.res_rem;
    dv  = bus.res_div3;
    id  = bus.res_id;
    $display("result id=%0d rem=%0d div3=%0d", id, rem, dv);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    idle_inputs();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    obs = {bus.req0_ready, bus.req1_ready, bus.res_valid, bus.res_rem,
           bus.res_div3, bus.res_id, bus.busy};
    n_cmp++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs got=%b want=%b", obs, 8'h00);
    end
    idle_inputs();
    do_reset();
  endtask

  task automatic test_single();
    logic [1:0] rem; logic dv, id; exp_t e; int n;
    sb_q.push_back(mk(0, 0));
    drive(0, 8'h00);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.res_valid) break;
    end
    n_cmp++;
    if (n !== W) begin
      n_err++;
      $display("FAIL single_latency got=%0d want=%0d", n, W);
    end
    get_result(rem, dv, id);
    e = sb_q.pop_front();
    n_cmp++;
    if ({id, rem, dv} !== {e.id, e.rem, (e.rem == 2'd0)}) begin
      n_err++;
      $display("FAIL single_result got id=%0d rem=%0d div3=%0d want id=%0d rem=%0d div3=%0d",
               id, rem, dv, e.id, e.rem, (e.rem == 2'd0));
    end
  endtask

  task automatic test_sweep();
    logic [1:0] rem; logic dv, id; exp_t e;
    logic [W-1:0] vals [3];
    vals[0] = 8'hFF; vals[1] = 8'h07; vals[2] = 8'h08;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk(1, int'(vals[i])));
      drive(1, vals[i]);
      get_result(rem, dv, id);
      e = sb_q.pop_front();
      n_cmp++;
      if ({id, rem, dv} !== {e.id, e.rem, (e.rem == 2'd0)}) begin
        n_err++;
        $display("FAIL sweep_0x%02h got id=%0d rem=%0d div3=%0d want id=%0d rem=%0d div3=%0d",
                 vals[i], id, rem, dv, e.id, e.rem, (e.rem == 2'd0));
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] rem; logic dv, id; exp_t e;
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    a[0] = 8'h03; b[0] = 8'h04;
    a[1] = 8'h09; b[1] = 8'h0A;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      bus.req0_data = a[r]; bus.req0_valid = 1'b1;
      bus.req1_data = b[r]; bus.req1_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
        n_err++;
        $display("FAIL contention_grant_%0d got r0r1=%b%b want 10",
                 r, bus.req0_ready, bus.req1_ready);
      end
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      sb_q.push_back(mk(0, int'(a[r])));
      sb_q.push_back(mk(1, int'(b[r])));
      for (int k = 0; k < 2; k++) begin
        if (k == 1) drive(1, b[r]);
        get_result(rem, dv, id);
        e = sb_q.pop_front();
        n_cmp++;
        if ({id, rem, dv} !== {e.id, e.rem, (e.rem == 2'd0)}) begin
          n_err++;
          $display("FAIL contention_%0d_%0d got id=%0d rem=%0d div3=%0d want id=%0d rem=%0d",
                   r, k, id, rem, dv, e.id, e.rem);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e; logic [6:0] obs; logic [6:0] want;
    bus.res_ready = 1'b0;
    sb_q.push_back(mk(1, 5));
    drive(1, 8'h05);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) break;
    end
    bus.req0_data = 8'h11; bus.req0_valid = 1'b1;
    bus.req1_data = 8'h12; bus.req1_valid = 1'b1;
    e = sb_q.pop_front();
    want = {1'b1, e.rem, (e.rem == 2'd0), e.id, 2'b00};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      obs = {bus.res_valid, bus.res_rem, bus.res_div3, bus.res_id,
             bus.req0_ready, bus.req1_ready};
      n_cmp++;
      if (obs !== want || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL stall_cycle_%0d got=%b busy=%b want=%b busy=1", c, obs, bus.busy, want);
      end
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    $display("result id=%0d rem=%0d div3=%0d", bus.res_id, bus.res_rem, bus.res_div3);
    n_cmp++;
    if (bus.res_valid !== 1'b1) begin
      n_err++;
      $display("FAIL release_valid got=%b want=1", bus.res_valid);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    obs = {bus.res_valid, bus.busy, bus.req0_ready, bus.req1_ready, 3'b000};
    n_cmp++;
    if (obs !== 7'b0010000) begin
      n_err++;
      $display("FAIL after_release got v/busy/r0/r1=%b want 0010", obs[6:3]);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_shift();
    logic [1:0] rem; logic dv, id; exp_t e; logic [7:0] obs; int nv;
    drive(0, 8'h81);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    obs = {bus.req0_ready, bus.req1_ready, bus.res_valid, bus.res_rem,
           bus.res_div3, bus.res_id, bus.busy};
    n_cmp++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL midshift_reset_outputs got=%b want=%b", obs, 8'h00);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nv = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) nv++;
    end
    n_cmp++;
    if (nv !== 0) begin
      n_err++;
      $display("FAIL midshift_no_result got active_cycles=%0d want 0", nv);
    end
    @(posedge clk);
    #1;
    sb_q.push_back(mk(0, 6));
    drive(0, 8'h06);
    get_result(rem, dv, id);
    e = sb_q.pop_front();
    n_cmp++;
    if ({id, rem, dv} !== {e.id, e.rem, (e.rem == 2'd0)}) begin
      n_err++;
      $display("FAIL midshift_followup got id=%0d rem=%0d div3=%0d want id=%0d rem=%0d",
               id, rem, dv, e.id, e.rem);
    end
  endtask

  task automatic test_exhaustive();
    int vals [256];
    int l0[$];
    int l1[$];
    int got, cyc, t, j;
    exp_t e;
    for (int i = 0; i < 256; i++) vals[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = vals[i]; vals[i] = vals[j]; vals[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(1, 0) == 1) l1.push_back(vals[i]);
      else                           l0.push_back(vals[i]);
    end
    got = 0;
    cyc = 0;
    fork
      begin
        foreach (l0[k]) begin
          q0.push_back(mk(0, l0[k]));
          drive(0, 8'(l0[k]));
          repeat ($urandom_range(2, 0)) @(posedge clk);
          #1;
        end
      end
      begin
        foreach (l1[k]) begin
          q1.push_back(mk(1, l1[k]));
          drive(1, 8'(l1[k]));
          repeat ($urandom_range(2, 0)) @(posedge clk);
          #1;
        end
      end
      begin
        while (got < 256 && cyc < 40000) begin
          @(posedge clk);
          #1;
          bus.res_ready = ($urandom_range(3, 0) != 0);
          @(negedge clk);
          cyc++;
          if (bus.res_valid && bus.res_ready) begin
            $display("result id=%0d rem=%0d div3=%0d", bus.res_id, bus.res_rem, bus.res_div3);
            got++;
            n_cmp++;
            if ((bus.res_id == 1'b0 && q0.size() == 0) || (bus.res_id == 1'b1 && q1.size() == 0)) begin
              n_err++;
              $display("FAIL exh_unexpected got result for id=%0d want none pending", bus.res_id);
            end else begin
              e = bus.res_id ? q1.pop_front() : q0.pop_front();
              if ({bus.res_rem, bus.res_div3} !== {e.rem, (e.rem == 2'd0)}) begin
                n_err++;
                $display("FAIL exh_result id=%0d got rem=%0d div3=%0d want rem=%0d div3=%0d",
                         bus.res_id, bus.res_rem, bus.res_div3, e.rem, (e.rem == 2'd0));
              end
            end
          end
        end
      end
    join
    bus.res_ready = 1'b1;
    n_cmp++;
    if (got !== 256 || q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL exh_count got=%0d pending=%0d want 256 pending=0", got, q0.size() + q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_contention();
    test_backpressure();
    test_reset_mid_shift();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
